// File: rtl/register_writeback_pkg.sv
// register_writeback_pkg: shared types and sizes for the register-file writeback path.
package register_writeback_pkg;
    localparam int XLEN     = 32;
    localparam int WB_DEPTH = 4;
    localparam int AW       = 5;

    typedef struct packed {
        logic [AW-1:0]   waddr;
        logic [XLEN-1:0] wdata;
    } wb_entry_type;

    typedef struct packed {
        logic            alu_valid;
        logic [AW-1:0]   alu_waddr;
        logic [XLEN-1:0] alu_wdata;
        logic            lsu_valid;
        logic [AW-1:0]   lsu_waddr;
        logic [XLEN-1:0] lsu_wdata;
        logic            iss_valid;
        logic [AW-1:0]   iss_waddr;
        logic            chk_rden1;
        logic [AW-1:0]   chk_raddr1;
        logic            chk_rden2;
        logic [AW-1:0]   chk_raddr2;
        logic            chk_wren;
        logic [AW-1:0]   chk_waddr;
    } writeback_in_type;

    typedef struct packed {
        logic            lsu_ready;
        logic            hazard;
        logic            wb_wren;
        logic [AW-1:0]   wb_waddr;
        logic [XLEN-1:0] wb_wdata;
    } writeback_out_type;
endpackage

// File: rtl/register_writeback_fifo.sv
// register_writeback_fifo: DEPTH-entry synchronous FIFO for long-latency results.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module register_writeback_fifo
    import register_writeback_pkg::*;
#(
    parameter int DEPTH = WB_DEPTH
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_push,
    input  wb_entry_type i_entry,
    input  logic         i_pop,
    output logic         o_full,
    output logic         o_empty,
    output wb_entry_type o_head
);
    localparam int PW = $clog2(DEPTH);

    logic [PW:0]  r_wptr;
    logic [PW:0]  r_rptr;
    wb_entry_type r_mem [DEPTH];

    assign o_empty = r_wptr == r_rptr;
    assign o_full  = (r_wptr[PW] != r_rptr[PW]) && (r_wptr[PW-1:0] == r_rptr[PW-1:0]);
    assign o_head  = r_mem[r_rptr[PW-1:0]];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (i_push) r_wptr <= r_wptr + 1'b1;
            if (i_pop)  r_rptr <= r_rptr + 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_push) r_mem[r_wptr[PW-1:0]] <= i_entry;
    end
endmodule

// File: rtl/register_writeback.sv
// register_writeback: merges ALU and long-latency results onto the single register-file
// write port, tracks registers with outstanding long-latency writes and flags decode hazards.
module register_writeback
    import register_writeback_pkg::*;
#(
    parameter int DEPTH = WB_DEPTH
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_alu_valid,
    input  logic [AW-1:0]   i_alu_waddr,
    input  logic [XLEN-1:0] i_alu_wdata,
    input  logic            i_lsu_valid,
    output logic            o_lsu_ready,
    input  logic [AW-1:0]   i_lsu_waddr,
    input  logic [XLEN-1:0] i_lsu_wdata,
    input  logic            i_iss_valid,
    input  logic [AW-1:0]   i_iss_waddr,
    input  logic            i_chk_rden1,
    input  logic [AW-1:0]   i_chk_raddr1,
    input  logic            i_chk_rden2,
    input  logic [AW-1:0]   i_chk_raddr2,
    input  logic            i_chk_wren,
    input  logic [AW-1:0]   i_chk_waddr,
    output logic            o_hazard,
    output logic            o_wb_wren,
    output logic [AW-1:0]   o_wb_waddr,
    output logic [XLEN-1:0] o_wb_wdata
);
    logic            w_push;
    logic            w_pop;
    logic            w_full;
    logic            w_empty;
    wb_entry_type    w_head;
    logic [31:0]     w_set;
    logic [31:0]     w_clr;
    logic            w_wbm1;
    logic            w_wbm2;
    logic [31:0]     r_busy;
    logic            r_wb_wren;
    logic [AW-1:0]   r_wb_waddr;
    logic [XLEN-1:0] r_wb_wdata;

    register_writeback_fifo #(.DEPTH(DEPTH)) u_fifo (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_push  (w_push),
        .i_entry ('{waddr: i_lsu_waddr, wdata: i_lsu_wdata}),
        .i_pop   (w_pop),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_head  (w_head)
    );

    // ALU has strict priority; the FIFO only drains on ALU-idle cycles.
    assign o_lsu_ready = !w_full;
    assign w_push      = i_lsu_valid && !w_full;
    assign w_pop       = !i_alu_valid && !w_empty;
    assign w_set       = (i_iss_valid && i_iss_waddr != '0) ? (32'd1 << i_iss_waddr) : '0;
    assign w_clr       = (w_pop && w_head.waddr != '0) ? (32'd1 << w_head.waddr) : '0;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_busy <= '0;
        else          r_busy <= (r_busy & ~w_clr) | w_set;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wb_wren  <= 1'b0;
            r_wb_waddr <= '0;
            r_wb_wdata <= '0;
        end else if (i_alu_valid) begin
            r_wb_wren  <= i_alu_waddr != '0;
            r_wb_waddr <= i_alu_waddr;
            r_wb_wdata <= i_alu_wdata;
        end else if (w_pop) begin
            r_wb_wren  <= w_head.waddr != '0;
            r_wb_waddr <= w_head.waddr;
            r_wb_wdata <= w_head.wdata;
        end else begin
            r_wb_wren  <= 1'b0;
        end
    end

    // A value sitting in wb_* is not yet readable from the register file.
    always_comb begin
        w_wbm1   = r_wb_wren && r_wb_waddr == i_chk_raddr1 && i_chk_raddr1 != '0;
        w_wbm2   = r_wb_wren && r_wb_waddr == i_chk_raddr2 && i_chk_raddr2 != '0;
        o_hazard = (i_chk_rden1 && (r_busy[i_chk_raddr1] || w_wbm1))
                 | (i_chk_rden2 && (r_busy[i_chk_raddr2] || w_wbm2))
                 | (i_chk_wren && r_busy[i_chk_waddr]);
    end

    assign o_wb_wren  = r_wb_wren;
    assign o_wb_waddr = r_wb_waddr;
    assign o_wb_wdata = r_wb_wdata;

    // Re-issue is legal only when the same cycle's pop retires the older write.
    a_iss_not_busy: assert property (@(posedge i_clk) disable iff (!i_rst_n)
        !(i_iss_valid && r_busy[i_iss_waddr] && !w_clr[i_iss_waddr]));
endmodule

// File: tb/tb_register_writeback.sv
// tb_register_writeback: directed vector table, hand sequences and a queue-based random model.
module tb_register_writeback;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        alu_v, lsu_v, iss_v, rd1, rd2, wr;
    logic [4:0]  alu_a, lsu_a, iss_a, ra1, ra2, wa;
    logic [31:0] alu_d, lsu_d;
    logic        lsu_rdy, haz, wb_wren;
    logic [4:0]  wb_waddr;
    logic [31:0] wb_wdata;
    int          n_chk = 0;
    int          n_fail = 0;

    typedef struct {
        logic alu_v; logic [4:0] alu_a; logic [31:0] alu_d;
        logic lsu_v; logic [4:0] lsu_a; logic [31:0] lsu_d;
        logic iss_v; logic [4:0] iss_a;
        logic rd1; logic [4:0] ra1; logic rd2; logic [4:0] ra2; logic wr; logic [4:0] wa;
        logic e_rdy; logic e_haz; logic e_wren; logic [4:0] e_waddr; logic [31:0] e_wdata;
    } vec_t;

    typedef struct { logic [4:0] a; logic [31:0] d; } ment_t;

    vec_t        tbl [10];
    vec_t        v;
    ment_t       mq [$];
    ment_t       me;
    bit          mbusy [32];
    logic        mwren;
    logic [4:0]  mwaddr;
    logic [31:0] mwdata;

    always #5 clk = ~clk;

    register_writeback dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_alu_valid(alu_v), .i_alu_waddr(alu_a), .i_alu_wdata(alu_d),
        .i_lsu_valid(lsu_v), .o_lsu_ready(lsu_rdy), .i_lsu_waddr(lsu_a), .i_lsu_wdata(lsu_d),
        .i_iss_valid(iss_v), .i_iss_waddr(iss_a),
        .i_chk_rden1(rd1), .i_chk_raddr1(ra1), .i_chk_rden2(rd2), .i_chk_raddr2(ra2),
        .i_chk_wren(wr), .i_chk_waddr(wa),
        .o_hazard(haz), .o_wb_wren(wb_wren), .o_wb_waddr(wb_waddr), .o_wb_wdata(wb_wdata)
    );

    function automatic vec_t mk(input logic av, input logic [4:0] aa, input logic [31:0] ad,
                                input logic lv, input logic [4:0] la, input logic [31:0] ld,
                                input logic rdy, input logic hz, input logic ew,
                                input logic [4:0] ea, input logic [31:0] ed);
        vec_t r;
        r.alu_v = av; r.alu_a = aa; r.alu_d = ad;
        r.lsu_v = lv; r.lsu_a = la; r.lsu_d = ld;
        r.iss_v = 1'b0; r.iss_a = 5'd0;
        r.rd1 = 1'b0; r.ra1 = 5'd0; r.rd2 = 1'b0; r.ra2 = 5'd0; r.wr = 1'b0; r.wa = 5'd0;
        r.e_rdy = rdy; r.e_haz = hz; r.e_wren = ew; r.e_waddr = ea; r.e_wdata = ed;
        return r;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input vec_t x);
        alu_v = x.alu_v; alu_a = x.alu_a; alu_d = x.alu_d;
        lsu_v = x.lsu_v; lsu_a = x.lsu_a; lsu_d = x.lsu_d;
        iss_v = x.iss_v; iss_a = x.iss_a;
        rd1 = x.rd1; ra1 = x.ra1; rd2 = x.rd2; ra2 = x.ra2; wr = x.wr; wa = x.wa;
    endtask

    // Called at a falling edge: combinational outputs checked before the rising edge,
    // registered outputs checked 1 time unit after it.
    task automatic apply(input vec_t x, input string tag);
        drive(x);
        #1;
        check({tag, "_lsu_ready"}, 32'(lsu_rdy), 32'(x.e_rdy));
        check({tag, "_hazard"}, 32'(haz), 32'(x.e_haz));
        @(posedge clk);
        #1;
        check({tag, "_wb_wren"}, 32'(wb_wren), 32'(x.e_wren));
        check({tag, "_wb_waddr"}, 32'(wb_waddr), 32'(x.e_waddr));
        check({tag, "_wb_wdata"}, wb_wdata, x.e_wdata);
        @(negedge clk);
    endtask

    task automatic do_reset();
        vec_t r;
        r = mk(1'b0, 5'd0, 0, 1'b1, 5'd3, 32'h33, 1'b1, 1'b0, 1'b0, 5'd0, 0);
        r.rd1 = 1'b1; r.ra1 = 5'd7;
        drive(r);
        rst_n = 1'b0;
        #1;
        check("rst_async_wren", 32'(wb_wren), 0);
        check("rst_async_waddr", 32'(wb_waddr), 0);
        check("rst_async_wdata", wb_wdata, 0);
        check("rst_async_hazard", 32'(haz), 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_hold_ready", 32'(lsu_rdy), 1);
        check("rst_hold_hazard", 32'(haz), 0);
        check("rst_hold_wren", 32'(wb_wren), 0);
        rst_n = 1'b1;
        r = mk(1'b0, 5'd0, 0, 1'b0, 5'd0, 0, 1'b1, 1'b0, 1'b0, 5'd0, 0);
        apply(r, "post_rst0");
        apply(r, "post_rst1");
    endtask

    function automatic logic wbm(input logic [4:0] a);
        return mwren && mwaddr == a && a != 5'd0;
    endfunction

    initial begin
        tbl[0] = mk(1, 5'd1, 32'h11, 1, 5'd2, 32'h22, 1, 0, 1, 5'd1, 32'h11);
        tbl[1] = mk(0, 5'd0, 0,      0, 5'd0, 0,      1, 0, 1, 5'd2, 32'h22);
        tbl[2] = mk(0, 5'd0, 0,      0, 5'd0, 0,      1, 0, 0, 5'd2, 32'h22);
        tbl[3] = mk(1, 5'd0, 32'hAA, 1, 5'd0, 32'hBB, 1, 0, 0, 5'd0, 32'hAA);
        tbl[4] = mk(0, 5'd0, 0,      0, 5'd0, 0,      1, 0, 0, 5'd0, 32'hBB);
        tbl[5] = mk(0, 5'd0, 0,      0, 5'd0, 0,      1, 0, 0, 5'd0, 32'hBB);
        tbl[6] = mk(0, 5'd0, 0,      1, 5'd3, 32'h33, 1, 0, 0, 5'd0, 32'hBB);
        tbl[7] = mk(0, 5'd0, 0,      0, 5'd0, 0,      1, 0, 1, 5'd3, 32'h33);
        tbl[8] = mk(0, 5'd0, 0,      0, 5'd0, 0,      1, 1, 0, 5'd3, 32'h33);
        tbl[8].rd1 = 1; tbl[8].ra1 = 5'd3;
        tbl[9] = mk(0, 5'd0, 0,      0, 5'd0, 0,      1, 0, 0, 5'd3, 32'h33);
        tbl[9].rd1 = 1; tbl[9].ra1 = 5'd3;

        rst_n = 1'b0;
        drive(mk(0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 0, 5'd0, 0));
        @(negedge clk);
        do_reset();

        for (int i = 0; i < 10; i++) apply(tbl[i], $sformatf("tbl%0d", i));

        // FIFO fills behind continuous ALU traffic, then drains in order
        for (int i = 0; i < 5; i++)
            apply(mk(1, 5'(10 + i), 32'(i), 1, 5'(20 + i), 32'(256 + i),
                     i < 4, 0, 1, 5'(10 + i), 32'(i)), $sformatf("full%0d", i));
        for (int k = 0; k < 5; k++)
            apply(mk(0, 5'd0, 0, k < 2, 5'd24, 32'h104, k != 0, 0, 1, 5'(20 + k), 32'(256 + k)),
                  $sformatf("drain%0d", k));
        apply(mk(0, 5'd0, 0, 0, 5'd0, 0, 1, 0, 0, 5'd24, 32'h104), "drain_end");

        // Scoreboard on x5
        v = mk(0, 5'd0, 0, 0, 5'd0, 0, 1, 0, 0, 5'd24, 32'h104);
        v.iss_v = 1; v.iss_a = 5'd5; v.rd1 = 1; v.ra1 = 5'd5;
        apply(v, "sb_iss");
        v = mk(1, 5'd9, 32'h99, 1, 5'd5, 32'h55, 1, 1, 1, 5'd9, 32'h99);
        v.rd1 = 1; v.ra1 = 5'd5;
        apply(v, "sb_push");
        v = mk(1, 5'd9, 32'h9a, 0, 5'd0, 0, 1, 1, 1, 5'd9, 32'h9a);
        v.wr = 1; v.wa = 5'd5;
        apply(v, "sb_wrchk");
        v = mk(0, 5'd0, 0, 0, 5'd0, 0, 1, 1, 1, 5'd5, 32'h55);
        v.rd1 = 1; v.ra1 = 5'd5;
        apply(v, "sb_pop");
        v = mk(0, 5'd0, 0, 0, 5'd0, 0, 1, 1, 0, 5'd5, 32'h55);
        v.rd1 = 1; v.ra1 = 5'd5;
        apply(v, "sb_wbm");
        v = mk(0, 5'd0, 0, 0, 5'd0, 0, 1, 0, 0, 5'd5, 32'h55);
        v.rd2 = 1; v.ra2 = 5'd5; v.wr = 1; v.wa = 5'd5;
        apply(v, "sb_clear");

        // Set/clear collision on x7, then x0 issue
        v = mk(0, 5'd0, 0, 0, 5'd0, 0, 1, 0, 0, 5'd5, 32'h55);
        v.iss_v = 1; v.iss_a = 5'd7;
        apply(v, "col_iss");
        v = mk(0, 5'd0, 0, 1, 5'd7, 32'h77, 1, 1, 0, 5'd5, 32'h55);
        v.rd2 = 1; v.ra2 = 5'd7;
        apply(v, "col_push");
        v = mk(0, 5'd0, 0, 0, 5'd0, 0, 1, 1, 1, 5'd7, 32'h77);
        v.iss_v = 1; v.iss_a = 5'd7; v.rd2 = 1; v.ra2 = 5'd7;
        apply(v, "col_popiss");
        v = mk(0, 5'd0, 0, 0, 5'd0, 0, 1, 1, 0, 5'd7, 32'h77);
        v.rd2 = 1; v.ra2 = 5'd7;
        apply(v, "col_after");
        v = mk(0, 5'd0, 0, 0, 5'd0, 0, 1, 1, 0, 5'd7, 32'h77);
        v.wr = 1; v.wa = 5'd7;
        apply(v, "col_busy");
        v = mk(0, 5'd0, 0, 0, 5'd0, 0, 1, 0, 0, 5'd7, 32'h77);
        v.iss_v = 1; v.rd1 = 1; v.rd2 = 1; v.wr = 1;
        apply(v, "x0_iss");
        v.iss_v = 0;
        apply(v, "x0_chk");

        // Reset while x7 is busy discards the scoreboard
        do_reset();
        v = mk(0, 5'd0, 0, 0, 5'd0, 0, 1, 0, 0, 5'd0, 0);
        v.rd1 = 1; v.ra1 = 5'd7; v.wr = 1; v.wa = 5'd7;
        apply(v, "rst_busy");

        // Random traffic against a queue/array model
        mq.delete();
        foreach (mbusy[i]) mbusy[i] = 0;
        mwren = 0; mwaddr = 5'd0; mwdata = 32'd0;
        for (int n = 0; n < 400; n++) begin
            v.alu_v = $urandom_range(0, 2) == 0;
            v.alu_a = 5'($urandom_range(0, 7)); v.alu_d = $urandom;
            v.lsu_v = $urandom_range(0, 1) == 1;
            v.lsu_a = 5'($urandom_range(0, 7)); v.lsu_d = $urandom;
            v.iss_a = 5'($urandom_range(0, 7));
            v.iss_v = ($urandom_range(0, 3) == 0) && !mbusy[v.iss_a];
            v.rd1 = $urandom_range(0, 1) == 1; v.ra1 = 5'($urandom_range(0, 7));
            v.rd2 = $urandom_range(0, 1) == 1; v.ra2 = 5'($urandom_range(0, 7));
            v.wr  = $urandom_range(0, 1) == 1; v.wa  = 5'($urandom_range(0, 7));
            v.e_rdy = mq.size() < 4;
            v.e_haz = (v.rd1 && (mbusy[v.ra1] || wbm(v.ra1)))
                   || (v.rd2 && (mbusy[v.ra2] || wbm(v.ra2)))
                   || (v.wr && mbusy[v.wa]);
            if (v.alu_v) begin
                mwren = v.alu_a != 0; mwaddr = v.alu_a; mwdata = v.alu_d;
            end else if (mq.size() > 0) begin
                me = mq.pop_front();
                mwren = me.a != 0; mwaddr = me.a; mwdata = me.d;
                mbusy[me.a] = 0;
            end else begin
                mwren = 0;
            end
            if (v.iss_v && v.iss_a != 0) mbusy[v.iss_a] = 1;
            if (v.lsu_v && v.e_rdy) mq.push_back('{a: v.lsu_a, d: v.lsu_d});
            v.e_wren = mwren; v.e_waddr = mwaddr; v.e_wdata = mwdata;
            apply(v, $sformatf("rnd%0d", n));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
